// File: rtl/uart_pixel_loader.sv
// uart_pixel_loader: decodes the UART byte stream into frame-buffer pixel
// writes (A5 X Y C) and buffer-swap requests (5A), with an inter-byte timeout.
// Optional build macro UART_PIXEL_LOADER_CHECKSUM_EN adds a fifth byte
// K = X ^ Y ^ C to pixel packets; a mismatching K drops the packet.
// X_BITS and Y_BITS are expected to be at most 8 (coordinates are byte-sized).
module uart_pixel_loader #(
  parameter int unsigned X_BITS  = 5,
  parameter int unsigned Y_BITS  = 3,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_dv,
  output logic                     fb_we,
  output logic [Y_BITS+X_BITS-1:0] fb_addr,
  output logic [2:0]               fb_data,
  output logic                     swap_out,
  output logic                     err_out,
  output logic                     busy_out
);

  localparam int unsigned A_W    = Y_BITS + X_BITS;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned X_SIZE = 32'd1 << X_BITS;
  localparam int unsigned Y_SIZE = 32'd1 << Y_BITS;

  localparam logic [7:0]       SYNC_PIX  = 8'hA5;
  localparam logic [7:0]       SYNC_SWAP = 8'h5A;
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT);

`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, GET_X, GET_Y, GET_C, GET_K} state_t;
`else
  typedef enum logic [2:0] {IDLE, GET_X, GET_Y, GET_C} state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
  logic [7:0]       c_q, c_d;
  logic             cks_ok;
`endif
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fb_we_q, fb_we_d;
  logic [A_W-1:0]   addr_q, addr_d;
  logic [2:0]       data_q, data_d;
  logic             swap_q, swap_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             commit;
  logic [2:0]       colour;
  logic             in_range;

  // Latched coordinates must fit the panel before a write is allowed.
  always_comb begin
    in_range = (32'(x_q) < X_SIZE) && (32'(y_q) < Y_SIZE);
  end

  // Packet parser, inter-byte timeout and output pulse generation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
    c_d     = c_q;
    cks_ok  = 1'b0;
`endif
    cnt_d   = cnt_q;
    fb_we_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    swap_d  = 1'b0;
    err_d   = 1'b0;
    commit  = 1'b0;
    colour  = 3'd0;

    if (rx_dv) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    if (rx_dv) begin
      case (state_q)
        IDLE: begin
          if (rx_data == SYNC_PIX) begin
            state_d = GET_X;
          end else if (rx_data == SYNC_SWAP) begin
            swap_d = 1'b1;
          end
        end
        GET_X: begin
          x_d     = rx_data;
          state_d = GET_Y;
        end
        GET_Y: begin
          y_d     = rx_data;
          state_d = GET_C;
        end
        GET_C: begin
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
          c_d     = rx_data;
          state_d = GET_K;
`else
          colour  = rx_data[2:0];
          commit  = 1'b1;
          state_d = IDLE;
`endif
        end
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
        GET_K: begin
          colour  = c_q[2:0];
          cks_ok  = (rx_data == (x_q ^ y_q ^ c_q));
          commit  = 1'b1;
          state_d = IDLE;
        end
`endif
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && (cnt_q == TO_LIM)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      cnt_d   = '0;
    end

    if (commit) begin
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
      if (in_range && cks_ok) begin
`else
      if (in_range) begin
`endif
        fb_we_d = 1'b1;
        addr_d  = {y_q[Y_BITS-1:0], x_q[X_BITS-1:0]};
        data_d  = colour;
      end else begin
        err_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State, packet fields, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
      c_q     <= '0;
`endif
      cnt_q   <= '0;
      fb_we_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      swap_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
      c_q     <= c_d;
`endif
      cnt_q   <= cnt_d;
      fb_we_q <= fb_we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      swap_q  <= swap_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = addr_q;
  assign fb_data  = data_q;
  assign swap_out = swap_q;
  assign err_out  = err_q;
  assign busy_out = busy_q;

endmodule

// File: tb/tb_uart_pixel_loader.sv
// Self-checking bench for uart_pixel_loader: directed packets plus random
// byte streams, compared every cycle against a packet-level reference model.
module tb_uart_pixel_loader;

  localparam int unsigned X_BITS  = 5;
  localparam int unsigned Y_BITS  = 3;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned A_W     = X_BITS + Y_BITS;
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
  localparam int PAYLOAD = 4;
`else
  localparam int PAYLOAD = 3;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     rx_data;
  logic           rx_dv;
  logic           fb_we;
  logic [A_W-1:0] fb_addr;
  logic [2:0]     fb_data;
  logic           swap_out;
  logic           err_out;
  logic           busy_out;

  uart_pixel_loader #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_dv(rx_dv),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .swap_out(swap_out), .err_out(err_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state: packet in progress, its bytes, time of last byte.
  bit             in_pkt = 0;
  logic [7:0]     pkt[$];
  int             last_k = 0;
  bit             m_we, m_swap, m_err;
  logic [A_W-1:0] m_addr = '0;
  logic [2:0]     m_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Byte sampled at clock edge k; predicts the pulses visible after edge k.
  task automatic model_byte(input logic [7:0] d, input int k);
    logic [7:0] x, y, c;
    bit ok;
    if (in_pkt && (k > last_k + int'(TIMEOUT) + 1)) in_pkt = 0;
    if (!in_pkt) begin
      if (d == 8'hA5) begin
        in_pkt = 1;
        pkt.delete();
        last_k = k;
      end else if (d == 8'h5A) begin
        m_swap = 1;
      end
    end else begin
      pkt.push_back(d);
      last_k = k;
      if (pkt.size() == PAYLOAD) begin
        in_pkt = 0;
        x = pkt[0]; y = pkt[1]; c = pkt[2];
        ok = (int'(x) < (1 << X_BITS)) && (int'(y) < (1 << Y_BITS));
        if (PAYLOAD == 4) ok = ok && (pkt[PAYLOAD-1] == (x ^ y ^ c));
        if (ok) begin
          m_we   = 1;
          m_addr = A_W'(int'(y) * (1 << X_BITS) + (int'(x) % (1 << X_BITS)));
          m_data = c[2:0];
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_to, exp_busy;
    exp_to   = in_pkt && (cyc == last_k + int'(TIMEOUT) + 1);
    exp_busy = in_pkt && (cyc <= last_k + int'(TIMEOUT));
    chk("fb_we",    32'(fb_we),    32'(m_we));
    chk("swap_out", 32'(swap_out), 32'(m_swap));
    chk("err_out",  32'(err_out),  32'(m_err | exp_to));
    chk("busy_out", 32'(busy_out), 32'(exp_busy));
    chk("fb_addr",  32'(fb_addr),  32'(m_addr));
    chk("fb_data",  32'(fb_data),  32'(m_data));
  endtask

  task automatic tick(input logic dv, input logic [7:0] d);
    rx_dv   = dv;
    rx_data = d;
    m_we = 0; m_swap = 0; m_err = 0;
    @(posedge clk);
    cyc++;
    if (dv && !reset) model_byte(d, cyc);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] d);
    tick(1'b1, d);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b1;
    in_pkt = 0;
    pkt.delete();
    m_addr = '0;
    m_data = '0;
    idle(n);
    reset = 1'b0;
  endtask

  task automatic pixel(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c);
    send(8'hA5); send(x); send(y); send(c);
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
    send(x ^ y ^ c);
`endif
  endtask

  function automatic int rand_gap();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 12) return 0;
    if (r < 17) return int'($urandom_range(1, 3));
    if (r == 17) return int'(TIMEOUT);
    if (r == 18) return int'(TIMEOUT) + 1;
    return int'(TIMEOUT) + 2;
  endfunction

  initial begin
    logic [7:0] x, y, c;
    int kind, nb;
    reset   = 1'b1;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    do_reset(3);

    // Basic write, swap, ignored junk byte.
    pixel(8'h03, 8'h02, 8'h06); idle(2);
    chk("dir_addr_43", 32'(fb_addr), 32'h43);
    send(8'h5A); idle(1);
    send(8'h7F); idle(1);

    // Out-of-range X, then corner pixel.
    pixel(8'h20, 8'h00, 8'h01); idle(1);
    pixel(8'h1F, 8'h07, 8'h07); idle(1);
    chk("dir_addr_ff", 32'(fb_addr), 32'hFF);
    pixel(8'h01, 8'h08, 8'h01); idle(1);

    // Timeout after A5,01 then recovery.
    send(8'hA5); send(8'h01); idle(int'(TIMEOUT) + 3);
    pixel(8'h00, 8'h00, 8'h04); idle(1);

    // Byte arriving exactly at the timeout limit is still accepted.
    send(8'hA5); send(8'h01); idle(int'(TIMEOUT));
    send(8'h02); idle(int'(TIMEOUT)); send(8'h03);
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
    send(8'h01 ^ 8'h02 ^ 8'h03);
`endif
    idle(1);

    // Sync byte as payload, back to back.
    pixel(8'h01, 8'h01, 8'hA5);
    pixel(8'h02, 8'h03, 8'h5A); idle(1);

    // Reset mid-packet discards the partial packet.
    send(8'hA5); send(8'h01); send(8'h01);
    do_reset(1);
    send(8'h04); idle(2);

`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
    send(8'hA5); send(8'h01); send(8'h02); send(8'h04); send(8'h07); idle(1);
    chk("cks_addr_41", 32'(fb_addr), 32'h41);
    send(8'hA5); send(8'h01); send(8'h02); send(8'h04); send(8'h06); idle(1);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 60) begin
        x = 8'($urandom_range(0, 40));
        y = 8'($urandom_range(0, 10));
        c = 8'($urandom);
        send(8'hA5); idle(rand_gap());
        send(x); idle(rand_gap());
        send(y); idle(rand_gap());
        send(c);
`ifdef UART_PIXEL_LOADER_CHECKSUM_EN
        idle(rand_gap());
        send(($urandom_range(0, 3) == 0) ? 8'($urandom) : (x ^ y ^ c));
`endif
      end else if (kind < 75) begin
        send(8'h5A);
      end else if (kind < 90) begin
        send(8'($urandom));
      end else if (kind < 97) begin
        nb = int'($urandom_range(0, PAYLOAD - 1));
        send(8'hA5);
        for (int j = 0; j < nb; j++) send(8'($urandom));
        idle(int'(TIMEOUT) + int'($urandom_range(1, 3)));
      end else begin
        send(8'hA5); send(8'($urandom));
        do_reset(int'($urandom_range(1, 2)));
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(int'(TIMEOUT) + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_pixel_loader.md
# uart_pixel_loader

Byte-stream command decoder between the UART receiver and the LED panel frame buffer. Consumes received bytes (`rx_data`/`rx_dv`), parses pixel-write and buffer-swap packets, and issues single-cycle write strobes into the panel's pixel memory. It sits directly downstream of the UART receive path and upstream of the scan/shift logic that drives red/green/blue/sclk/latch/a/b.

## Interface
Parameters:
- `X_BITS`, default 5: column address width; the panel is 2^X_BITS columns.
- `Y_BITS`, default 3: row address width; the panel is 2^Y_BITS rows.
- `TIMEOUT`, default 4095: maximum idle cycles allowed between bytes of one packet. Range 1..65535.

Ports:
- `clk`  in  1  sole clock; every register is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_dv` is high.
- `rx_dv`  in  1  one-cycle strobe per received byte.
- `fb_we`  out  1  one-cycle frame-buffer write strobe.
- `fb_addr`  out  Y_BITS+X_BITS  write address, {y, x}.
- `fb_data`  out  3  pixel colour, {r, g, b}.
- `swap_out`  out  1  one-cycle request to swap display/back buffers.
- `err_out`  out  1  one-cycle pulse on a dropped packet.
- `busy_out`  out  1  high while a packet is in progress (state != IDLE).

## Operation
- Packet formats:
  - Pixel write: 0xA5, X, Y, C. Colour is C[2:0] = {r, g, b]; C[7:3] is ignored.
  - Swap: 0x5A, single byte.
- States: IDLE, GET_X, GET_Y, GET_C, plus GET_K when checksum is compiled in. Transitions happen only on `rx_dv`, or on timeout.
  - IDLE:
    - 0xA5 -> GET_X.
    - 0x5A -> `swap_out` pulse; stay in IDLE.
    - Any other byte is discarded silently, with no `err_out`.
  - GET_X: latch X -> GET_Y.
  - GET_Y: latch Y -> GET_C.
  - GET_C: latch C. Without checksum, commit -> IDLE. With checksum -> GET_K.
- Commit:
  - If X < 2^X_BITS and Y < 2^Y_BITS: pulse `fb_we` with `fb_addr` = {Y[Y_BITS-1:0], X[X_BITS-1:0]} and `fb_data` = C[2:0].
  - Otherwise: no write, and pulse `err_out`.
- Sync bytes inside a packet are ordinary data. 0xA5 received in GET_X is X = 0xA5, not a resync.
- Timeout:
  - A 16-bit counter clears on every `rx_dv` and increments while state != IDLE.
  - When it reaches TIMEOUT: state -> IDLE, `err_out` pulse, counter clears.
  - If `rx_dv` arrives in the same cycle the counter reaches TIMEOUT, the byte is processed and the timeout does not fire.
- Reset mid-packet: state returns to IDLE, partial X/Y/C are discarded, and no write is issued.

## Timing
- Reset values: `fb_we`=0, `fb_addr`=0, `fb_data`=0, `swap_out`=0, `err_out`=0, `busy_out`=0, state IDLE, timeout counter 0.
- All outputs are registered.
- `fb_we`, `swap_out` and `err_out` go high in the cycle after the `rx_dv` edge that completes the packet, and stay high exactly 1 cycle.
- `fb_addr`/`fb_data` are updated in the same cycle as `fb_we` and hold their values until the next commit.
- `busy_out` rises the cycle after the sync byte and falls the cycle after commit, drop or timeout.
- Back-to-back `rx_dv` on consecutive cycles is accepted. Throughput is one byte per cycle; there is no backpressure.
- Timeout `err_out` occurs TIMEOUT+1 cycles after the last `rx_dv` of an incomplete packet.

## Configuration
- Macro `UART_PIXEL_LOADER_CHECKSUM_EN`.
- Defined:
  - Pixel packets carry a fifth byte K, and GET_C -> GET_K.
  - On K, commit only if K == X ^ Y ^ C. On mismatch: no write, `err_out` pulse.
  - Range check still applies.
  - The swap packet remains one byte.
- Undefined:
  - GET_K is absent and packets are 4 bytes.
  - K-related logic is not synthesised.

## Test plan
- Reset then bytes A5,03,02,06 (checksum off) -> one `fb_we` pulse with `fb_addr`={3'd2,5'd3}=0x43 and `fb_data`=3'b110; `busy_out` low afterwards.
- Byte 5A while idle -> `swap_out` high 1 cycle; no `fb_we`. Byte 7F while idle -> no output pulses.
- A5,20,00,01 with X_BITS=5 -> no `fb_we`; `err_out` 1 cycle; next A5,1F,07,07 -> write at 0xFF, data 3'b111.
- A5,01 then silence with TIMEOUT=16 -> `err_out` 17 cycles after the 01 byte; a subsequent A5,00,00,04 writes addr 0, data 3'b100.
- `reset` asserted after A5,01,01 and released, then 04 -> no write (04 discarded in IDLE), no `err_out`.
- With `UART_PIXEL_LOADER_CHECKSUM_EN`: A5,01,02,04,07 -> write addr 0x41, data 3'b100. Then A5,01,02,04,06 -> no write, `err_out` pulse.
